// File: rtl/gb_joypad_pkg.sv
// rtl/gb_joypad_pkg.sv - shared joypad constants and row mux helper
package gb_joypad_pkg;

    // Bit positions of each board button inside btn_n / stable
    localparam int BTN_RIGHT  = 0;
    localparam int BTN_LEFT   = 1;
    localparam int BTN_UP     = 2;
    localparam int BTN_DOWN   = 3;
    localparam int BTN_A      = 4;
    localparam int BTN_B      = 5;
    localparam int BTN_SELECT = 6;
    localparam int BTN_START  = 7;

    // Bit positions inside button_sel (JOYP bits 5:4); a 0 selects the row
    localparam int ROW_DIR = 0;
    localparam int ROW_ACT = 1;

    // Active-low row merge: an unselected row contributes all-ones, so
    // selecting both rows reports a press from either one.
    function automatic logic [3:0] row_mux(input logic [7:0] levels,
                                           input logic [1:0] sel);
        logic [3:0] dir_row;
        logic [3:0] act_row;
        dir_row = sel[ROW_DIR] ? 4'hF : levels[BTN_DOWN:BTN_RIGHT];
        act_row = sel[ROW_ACT] ? 4'hF : levels[BTN_START:BTN_A];
        return dir_row & act_row;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// rtl/debounce_bit.sv - two-flop synchronizer plus counting debouncer for one button
//
// Ports:
//   clock, reset : system clock, asynchronous active-high reset
//   btn_n        : raw active-low button, asynchronous to clock
//   stable       : debounced level (1 = released)
module debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 20971,
    parameter int CNT_W           = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_n,
    output logic stable
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1     <= 1'b1;
            s2     <= 1'b1;
            stable <= 1'b1;
            cnt    <= '0;
        end else begin
            s1 <= btn_n;
            s2 <= s1;
            // Any sample that agrees with the accepted level discards the run
            if (s2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= s2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/joypad_scanner.sv
// rtl/joypad_scanner.sv - debounced joypad row scanner with interrupt request
//
// Ports:
//   clock, reset : system clock, asynchronous active-high reset
//   btn_n        : raw active-low buttons (Right, Left, Up, Down, A, B, Select, Start)
//   button_sel   : JOYP row select, bit 0 low = direction row, bit 1 low = action row
//   button_data  : registered active-low selected nibble
//   int_pulse    : one-cycle request on any 1->0 transition of button_data
module joypad_scanner
    import gb_joypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20971,
    parameter int CNT_W           = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] btn_n,
    input  logic [1:0] button_sel,
    output logic [3:0] button_data,
    output logic       int_pulse
);

    logic [7:0] stable;
    logic [3:0] next_data;

    for (genvar i = 0; i < 8; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_debounce (
            .clock (clock),
            .reset (reset),
            .btn_n (btn_n[i]),
            .stable(stable[i])
        );
    end

    assign next_data = row_mux(stable, button_sel);

    // A falling bit can come from a press or from a row-select change;
    // both must raise the request, rising bits never do.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            button_data <= 4'hF;
            int_pulse   <= 1'b0;
        end else begin
            button_data <= next_data;
            int_pulse   <= |(button_data & ~next_data);
        end
    end

endmodule

// File: tb/tb_joypad_scanner.sv
// tb/tb_joypad_scanner.sv - scoreboard bench for joypad_scanner
module tb_joypad_scanner;
    import gb_joypad_pkg::*;

    localparam int D = 4;

    typedef struct packed {
        logic [3:0] data;
        logic       pulse;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] btn_n = 8'hFF;
    logic [1:0] button_sel = 2'b11;
    logic [3:0] button_data;
    logic       int_pulse;

    int total = 0;
    int bad   = 0;

    exp_t       sb_q[$];
    logic [7:0] hist[$];
    logic [7:0] m_level;
    logic [3:0] m_prev;
    logic [3:0] m_next;
    logic       m_run;

    joypad_scanner #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (3)
    ) dut (
        .clock      (clk),
        .reset      (rst),
        .btn_n      (btn_n),
        .button_sel (button_sel),
        .button_data(button_data),
        .int_pulse  (int_pulse)
    );

    always #5 clk = ~clk;

    // Nibble a real Game Boy would read: a bit reads 0 when its button is held
    // in any row the CPU currently selects.
    function automatic logic [3:0] visible(input logic [7:0] held_n, input logic [1:0] sel);
        logic [3:0] r;
        for (int j = 0; j < 4; j++) begin
            r[j] = !((!sel[0] && !held_n[j]) || (!sel[1] && !held_n[j+4]));
        end
        return r;
    endfunction

    // Reference model: a button's accepted level changes once the raw input,
    // seen through two clocks of synchronizer delay, has shown the opposite
    // level for D consecutive samples.
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                hist.delete();
                for (int i = 0; i < D + 2; i++) hist.push_back(8'hFF);
                m_level = 8'hFF;
                m_prev  = 4'hF;
                sb_q.delete();
            end else begin
                m_next = visible(m_level, button_sel);
                sb_q.push_back('{data: m_next, pulse: |(m_prev & ~m_next)});
                m_prev = m_next;
                for (int b = 0; b < 8; b++) begin
                    m_run = 1'b1;
                    for (int j = 1; j <= D; j++) begin
                        if (hist[j][b] == m_level[b]) m_run = 1'b0;
                    end
                    if (m_run) m_level[b] = ~m_level[b];
                end
                hist.push_back(btn_n);
                void'(hist.pop_front());
            end
        end
    end

    // Monitor: every clock the DUT presents a new registered output.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                total++;
                if (sb_q.size() == 0) begin
                    bad++;
                    $display("FAIL scoreboard_empty actual=%h/%b required=entry", button_data, int_pulse);
                end else begin
                    e = sb_q.pop_front();
                    if (button_data !== e.data) begin
                        bad++;
                        $display("FAIL sb_button_data t=%0t actual=%h required=%h", $time, button_data, e.data);
                    end
                    total++;
                    if (int_pulse !== e.pulse) begin
                        bad++;
                        $display("FAIL sb_int_pulse t=%0t actual=%b required=%b", $time, int_pulse, e.pulse);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int actual, input int required);
        total++;
        if (actual != required) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, actual, required);
        end
    endtask

    // Bounded observation: edges until button_data first equals target,
    // number of pulse cycles seen and AND of all observed nibbles.
    task automatic watch(input logic [3:0] target, input int max_edges,
                         output int first, output int pulses, output logic [3:0] and_data);
        first = -1;
        pulses = 0;
        and_data = 4'hF;
        for (int n = 1; n <= max_edges; n++) begin
            @(posedge clk);
            #1;
            if (int_pulse) pulses++;
            and_data = and_data & button_data;
            if (first < 0 && button_data == target) first = n;
        end
    endtask

    task automatic async_reset_check(input string name);
        #2 rst = 1'b1;
        #1;
        check({name, "_data"}, int'(button_data), 4'hF);
        check({name, "_pulse"}, int'(int_pulse), 0);
        @(negedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int first;
        int pulses;
        logic [3:0] anded;

        // Reset with all buttons held: nothing until 7 clocks after deassert
        btn_n = 8'h00;
        button_sel = 2'b00;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_data", int'(button_data), 4'hF);
        check("reset_pulse", int'(int_pulse), 0);
        @(negedge clk);
        #1 rst = 1'b0;
        watch(4'h0, 10, first, pulses, anded);
        check("held_reset_first_edge", first, 7);
        check("held_reset_pulses", pulses, 1);

        // Mid-cycle asynchronous reset clears outputs immediately
        @(posedge clk);
        btn_n = 8'hFF;
        button_sel = 2'b10;
        async_reset_check("async_reset");
        watch(4'hF, 10, first, pulses, anded);

        // Press latency on Right, then release
        btn_n[BTN_RIGHT] = 1'b0;
        watch(4'hE, 10, first, pulses, anded);
        check("press_first_edge", first, 7);
        check("press_pulses", pulses, 1);
        btn_n[BTN_RIGHT] = 1'b1;
        watch(4'hF, 10, first, pulses, anded);
        check("release_first_edge", first, 7);
        check("release_pulses", pulses, 0);

        // Bounce rejection on A with the action row selected
        button_sel = 2'b01;
        pulses = 0;
        anded = 4'hF;
        for (int k = 0; k < 4; k++) begin
            int p1, p2, f1;
            logic [3:0] a1, a2;
            btn_n[BTN_A] = 1'b0;
            watch(4'h0, 3, f1, p1, a1);
            btn_n[BTN_A] = 1'b1;
            watch(4'h0, 3, f1, p2, a2);
            pulses = pulses + p1 + p2;
            anded = anded & a1 & a2;
        end
        watch(4'h0, 6, first, first, anded);
        check("bounce_pulses", pulses, 0);
        check("bounce_data", int'(anded), 4'hF);
        btn_n[BTN_A] = 1'b0;
        watch(4'hE, 10, first, pulses, anded);
        check("bounce_hold_first_edge", first, 7);

        // Row select with A and Down held
        button_sel = 2'b11;
        btn_n = 8'hFF;
        btn_n[BTN_A] = 1'b0;
        btn_n[BTN_DOWN] = 1'b0;
        watch(4'hF, 10, first, pulses, anded);
        check("rowsel_none", int'(button_data), 4'hF);
        button_sel = 2'b10;
        watch(4'h7, 2, first, pulses, anded);
        check("rowsel_dir_edge", first, 1);
        check("rowsel_dir_pulse", pulses, 1);
        button_sel = 2'b01;
        watch(4'hE, 2, first, pulses, anded);
        check("rowsel_act_edge", first, 1);
        check("rowsel_act_pulse", pulses, 1);
        button_sel = 2'b00;
        watch(4'h6, 2, first, pulses, anded);
        check("rowsel_both_edge", first, 1);
        check("rowsel_both_pulse", pulses, 1);

        // Right and Left pressed together
        button_sel = 2'b10;
        btn_n = 8'hFF;
        watch(4'hF, 10, first, pulses, anded);
        btn_n[BTN_RIGHT] = 1'b0;
        btn_n[BTN_LEFT] = 1'b0;
        watch(4'hC, 10, first, pulses, anded);
        check("multi_first_edge", first, 7);
        check("multi_pulses", pulses, 1);

        // Reset two counts into a press: full latency restarts
        btn_n = 8'hFF;
        watch(4'hF, 10, first, pulses, anded);
        btn_n[BTN_UP] = 1'b0;
        repeat (4) @(posedge clk);
        async_reset_check("midcount_reset");
        watch(4'hB, 10, first, pulses, anded);
        check("midcount_first_edge", first, 7);
        check("midcount_pulses", pulses, 1);

        // Randomized traffic, checked entirely by the scoreboard
        for (int r = 0; r < 250; r++) begin
            int hold;
            @(posedge clk);
            #2;
            if ($urandom_range(0, 1) == 0) btn_n[$urandom_range(0, 7)] ^= 1'b1;
            else if ($urandom_range(0, 3) == 0) btn_n = 8'($urandom);
            if ($urandom_range(0, 3) == 0) button_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 60) == 0) begin
                #1 rst = 1'b1;
                @(negedge clk);
                #1 rst = 1'b0;
            end
            hold = $urandom_range(1, 9);
            repeat (hold) @(posedge clk);
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/joypad_scanner.md
# joypad_scanner

Front end of the Game Boy joypad path, directly upstream of the `joypad` register block. It synchronizes and debounces the eight active-low board buttons. It then applies the JOYP row select (`button_sel`, driven by the joypad register) to produce the 4-bit active-low `button_data` nibble. It also raises the joypad interrupt request pulse on any high-to-low transition of that nibble.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 20971 (~5 ms at 4.194304 MHz): number of consecutive clocks a synchronized level must differ from the stable level before it is accepted. Legal range ≥ 2.
- `CNT_W`, default 16: counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- `clock`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `btn_n`, in, 8: raw board buttons, active-low, asynchronous to `clock`. Bit 0 Right, 1 Left, 2 Up, 3 Down, 4 A, 5 B, 6 Select, 7 Start.
- `button_sel`, in, 2: JOYP bits 5:4 from the joypad register. Bit 0 low selects the direction row; bit 1 low selects the action row.
- `button_data`, out, 4: registered, active-low selected nibble; feeds JOYP bits 3:0.
- `int_pulse`, out, 1: registered one-cycle joypad interrupt request, consumed by the interrupt controller.

## Operation
- Synchronizer: two flops per bit (`s1`, `s2`), reset to 1.
- Debounce per bit:
  - Keeps a `stable` level (reset 1 = released) and a counter `cnt` (reset 0).
  - If `s2 == stable`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `stable <= s2` and `cnt <= 0`.
  - Else: `cnt <= cnt+1`.
  - Bits are fully independent. Any mismatch shorter than `DEBOUNCE_CYCLES` clocks resets the count and is discarded.
- Row mux (combinational `next_data`):
  - `dir = stable[3:0]`, `act = stable[7:4]`.
  - `next_data = (button_sel[0] ? 4'hF : dir) & (button_sel[1] ? 4'hF : act)`.
  - Both rows selected gives the bitwise AND (either pressed → 0).
  - Neither row selected gives 4'hF.
- Output register: each clock, `button_data <= next_data` and `int_pulse <= |(button_data & ~next_data)`.
- The interrupt fires on any 1→0 bit transition, including one caused by a `button_sel` change. 0→1 transitions never fire.

## Timing
- Reset values: `button_data` = 4'hF; `int_pulse` = 0; all `s1`, `s2`, `stable` = 1; all `cnt` = 0. Reset asserted mid-count abandons the count.
- Press latency, with `btn_n[i]` changing between edge 0 and edge 1 and held:
  - `s2` changes at edge 2.
  - `cnt` reaches `DEBOUNCE_CYCLES-1` at edge `DEBOUNCE_CYCLES+1`.
  - `stable` updates at edge `DEBOUNCE_CYCLES+2`.
  - `button_data` and `int_pulse` update at edge `DEBOUNCE_CYCLES+3`.
- Release latency is the same.
- `button_sel` change: `button_data` reflects it one clock later; `int_pulse` is asserted in that same cycle if any bit fell.
- `int_pulse` is high for exactly one cycle per falling event. Simultaneous falls on several bits produce a single pulse. A fall on one bit while another rises still pulses.
- Bounce: a toggle at any point before the count completes restarts the count from 0.

## Structure
- Shared package `gb_joypad_pkg`:
  - Button index constants `BTN_RIGHT`…`BTN_START` (0–7).
  - `ROW_DIR` = 0 and `ROW_ACT` = 1 select-bit indices.
- Sub-module `debounce_bit` (sync flops + counter + stable level; parameters `DEBOUNCE_CYCLES`, `CNT_W`), instantiated 8 times via generate. The top level holds the mux, output register and interrupt logic.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4.
- Reset: assert `reset` asynchronously mid-cycle → `button_data` = 4'hF and `int_pulse` = 0 immediately; hold `btn_n` = 8'h00 during reset → no pulse until 7 clocks after deassert.
- Press latency: `button_sel` = 2'b10, drive `btn_n[0]` low just after edge 0 → `button_data` = 4'hE first seen after edge 7, `int_pulse` high for exactly that one cycle; release → 4'hF after 7 more edges, no pulse.
- Bounce rejection: toggle `btn_n[4]` low for 3 clocks then high, repeatedly, with `button_sel` = 2'b01 → `button_data` stays 4'hF, `int_pulse` never asserted; hold low 5+ clocks → 4'hE.
- Row select: hold A (bit 4) and Down (bit 3) pressed and stable; step `button_sel` 2'b11→2'b10→2'b01→2'b00 → `button_data` 4'hF, 4'h7, 4'hE, 4'h6, each one clock after the sel change, with `int_pulse` on each of those three transitions.
- Multi-bit: press Right and Left in the same cycle with direction row selected → single one-cycle `int_pulse`, `button_data` = 4'hC.
- Mid-count reset: assert `reset` at count 2 of a press → `stable` remains released; after deassert the press takes a full 7 edges from re-synchronization.
